// File: rtl/tinyqv_alu_pkg.sv
// Shared ALU definitions: op encoding {funct7[5], funct3} and register-file geometry.
// Both the serial ALU and tinyqv_registers pull widths from here.
package tinyqv_alu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 4;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_OR, ALU_AND: op_legal = 1'b1;
      default:                  op_legal = 1'b0;
    endcase
  endfunction

  // Compare ops run as a subtraction so the final carry/sign gives the answer.
  function automatic logic op_subtracts(input logic [3:0] op);
    op_subtracts = (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
  endfunction

endpackage

// File: rtl/tinyqv_alu_slice.sv
// Combinational W-bit add/subtract/logic slice with carry in/out; zero latency.
// No handshake: the caller sequences slices and registers the carry.
module tinyqv_alu_slice
  import tinyqv_alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] y,
  output logic         cout
);

  logic [W-1:0] b_eff;
  logic [W:0]   sum;

  always_comb begin
    b_eff = op_subtracts(op) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, cin};
    cout  = sum[W];
    case (op)
      ALU_XOR: y = a ^ b;
      ALU_OR:  y = a | b;
      ALU_AND: y = a & b;
      default: y = sum[W-1:0];
    endcase
  end

endmodule

// File: rtl/tinyqv_serial_alu.sv
// Serial execute stage: one BITS_PER_CYCLE slice per clock, LSB first; result 32/BITS_PER_CYCLE cycles after accept.
// No queueing: start is only taken while idle; wr_en/illegal pulse for one cycle at completion.
module tinyqv_serial_alu
  import tinyqv_alu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [3:0]            op,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]       a,
  input  logic [XLEN-1:0]       b,
  output logic                  busy,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       rd_in,
  output logic                  illegal
);

  localparam int NUM_SLICES = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W      = $clog2(NUM_SLICES);
  localparam int BPC        = BITS_PER_CYCLE;

  logic [CNT_W-1:0]      cnt;
  logic [XLEN-1:0]       a_sh;
  logic [XLEN-1:0]       b_sh;
  logic [XLEN-BPC-1:0]   res_sh;
  logic                  carry;
  logic [3:0]            op_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  a_sign;
  logic                  b_sign;

  logic [BPC-1:0]  slice_y;
  logic            slice_c;
  logic            last;
  logic            legal;
  logic            lt;
  logic [XLEN-1:0] full;
  logic [XLEN-1:0] final_res;

  tinyqv_alu_slice #(.W(BPC)) u_slice (
    .op   (op_q),
    .a    (a_sh[BPC-1:0]),
    .b    (b_sh[BPC-1:0]),
    .cin  (carry),
    .y    (slice_y),
    .cout (slice_c)
  );

  always_comb begin
    last  = (cnt == CNT_W'(NUM_SLICES - 1));
    legal = op_legal(op_q);
    full  = {slice_y, res_sh};
    // Operands have shifted away by now, so signs come from the accept-time copy.
    lt    = (a_sign ^ b_sign) ? a_sign : full[XLEN-1];
    case (op_q)
      ALU_SLTU: final_res = {{(XLEN-1){1'b0}}, ~slice_c};
      ALU_SLT:  final_res = {{(XLEN-1){1'b0}}, lt};
      default:  final_res = full;
    endcase
    if (!legal) final_res = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy    <= 1'b0;
      wr_en   <= 1'b0;
      illegal <= 1'b0;
      rd      <= '0;
      rd_in   <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      a_sign  <= 1'b0;
      b_sign  <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      illegal <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy   <= 1'b1;
          a_sh   <= a;
          b_sh   <= b;
          op_q   <= op;
          rd_q   <= rd_addr;
          a_sign <= a[XLEN-1];
          b_sign <= b[XLEN-1];
          carry  <= op_subtracts(op);
          cnt    <= '0;
        end
      end else begin
        a_sh   <= a_sh >> BPC;
        b_sh   <= b_sh >> BPC;
        res_sh <= full[XLEN-1:BPC];
        carry  <= slice_c;
        cnt    <= cnt + CNT_W'(1);
        if (last) begin
          busy    <= 1'b0;
          rd      <= rd_q;
          rd_in   <= final_res;
          wr_en   <= legal && (rd_q != '0);
          illegal <= !legal;
        end
      end
    end
  end

endmodule

// File: tb/tb_tinyqv_serial_alu.sv
// Bench for tinyqv_serial_alu: four instances (BITS_PER_CYCLE 4,1,2,8) share stimulus;
// results are compared against an arithmetic reference of the RV32 ops.
module tb_tinyqv_serial_alu;

  localparam int NDUT = 4;
  localparam int BPC_TAB [NDUT] = '{4, 1, 2, 8};

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [3:0]  op;
  logic [3:0]  rd_addr;
  logic [31:0] a, b;

  logic        busy_v    [NDUT];
  logic        wr_en_v   [NDUT];
  logic        illegal_v [NDUT];
  logic [3:0]  rd_v      [NDUT];
  logic [31:0] rd_in_v   [NDUT];

  int checks = 0;
  int errors = 0;

  logic [3:0] legal_ops   [7] = '{4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111};
  logic [3:0] illegal_ops [9] = '{4'b0001, 4'b0101, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    tinyqv_serial_alu #(.BITS_PER_CYCLE(BPC_TAB[g])) u_dut (
      .clk     (clk),
      .rstn    (rstn),
      .start   (start),
      .op      (op),
      .rd_addr (rd_addr),
      .a       (a),
      .b       (b),
      .busy    (busy_v[g]),
      .wr_en   (wr_en_v[g]),
      .rd      (rd_v[g]),
      .rd_in   (rd_in_v[g]),
      .illegal (illegal_v[g])
    );
  end

  // Reference: {legal, result} straight from the instruction semantics.
  function automatic logic [32:0] ref_alu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      4'b0000: ref_alu = {1'b1, x + y};
      4'b1000: ref_alu = {1'b1, x - y};
      4'b0010: ref_alu = {1'b1, 31'd0, ($signed(x) < $signed(y))};
      4'b0011: ref_alu = {1'b1, 31'd0, (x < y)};
      4'b0100: ref_alu = {1'b1, x ^ y};
      4'b0110: ref_alu = {1'b1, x | y};
      4'b0111: ref_alu = {1'b1, x & y};
      default: ref_alu = {1'b0, 32'd0};
    endcase
  endfunction

  // Caller is at a negedge. Returns at the negedge where the instance's busy has dropped.
  task automatic issue(input int idx, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [3:0] r, output int lat, output logic we, output logic il,
                       output logic [3:0] rdo, output logic [31:0] res);
    op = o; a = x; b = y; rd_addr = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; op = 4'($urandom); rd_addr = 4'($urandom);
    lat = 0;
    while (busy_v[idx] === 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    we = wr_en_v[idx]; il = illegal_v[idx]; rdo = rd_v[idx]; res = rd_in_v[idx];
  endtask

  task automatic test_reset;
    rstn = 1'b0; start = 1'b0; op = '0; rd_addr = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if ({busy_v[i], wr_en_v[i], illegal_v[i], rd_v[i], rd_in_v[i]} !== 39'd0) begin
        errors++;
        $display("FAIL reset_state dut%0d: busy=%b wr_en=%b illegal=%b rd=%h rd_in=%h, all must be 0",
                 i, busy_v[i], wr_en_v[i], illegal_v[i], rd_v[i], rd_in_v[i]);
      end
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_wrap;
    int lat; logic we, il; logic [3:0] rdo; logic [31:0] res;
    issue(0, 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 4'd5, lat, we, il, rdo, res);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL add_wrap_latency: got %0d expected 8", lat); end
    checks++;
    if ({we, il, rdo, res} !== {1'b1, 1'b0, 4'd5, 32'h0}) begin
      errors++;
      $display("FAIL add_wrap_result: wr_en=%b illegal=%b rd=%0d rd_in=%h expected 1 0 5 00000000", we, il, rdo, res);
    end
    @(negedge clk);
    checks++;
    if ({wr_en_v[0], rd_v[0], rd_in_v[0]} !== {1'b0, 4'd5, 32'h0}) begin
      errors++;
      $display("FAIL add_wrap_hold: wr_en=%b rd=%0d rd_in=%h expected 0 5 00000000", wr_en_v[0], rd_v[0], rd_in_v[0]);
    end
  endtask

  task automatic test_sub_cmp;
    logic [3:0]  ops [3] = '{4'b1000, 4'b0010, 4'b0011};
    logic [31:0] va  [2] = '{32'h0000_0003, 32'hFFFF_FFFE};
    int lat; logic we, il; logic [3:0] rdo; logic [31:0] res; logic [32:0] exp;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 3; i++) begin
        exp = ref_alu(ops[i], va[s], va[1-s]);
        issue(0, ops[i], va[s], va[1-s], 4'(i + 1), lat, we, il, rdo, res);
        checks++;
        if ({lat == 8, we, res} !== {1'b1, 1'b1, exp[31:0]}) begin
          errors++;
          $display("FAIL sub_cmp op=%b a=%h b=%h: lat=%0d wr_en=%b rd_in=%h expected lat 8 wr_en 1 rd_in %h",
                   ops[i], va[s], va[1-s], lat, we, res, exp[31:0]);
        end
      end
    end
  endtask

  task automatic test_logic_x0;
    logic [3:0] ops [3] = '{4'b0100, 4'b0110, 4'b0111};
    int lat; logic we, il; logic [3:0] rdo; logic [31:0] res; logic [32:0] exp;
    for (int i = 0; i < 3; i++) begin
      exp = ref_alu(ops[i], 32'hF0F0_A5A5, 32'h0FF0_FFFF);
      issue(0, ops[i], 32'hF0F0_A5A5, 32'h0FF0_FFFF, 4'd7, lat, we, il, rdo, res);
      checks++;
      if ({we, rdo, res} !== {1'b1, 4'd7, exp[31:0]}) begin
        errors++;
        $display("FAIL logic op=%b: wr_en=%b rd=%0d rd_in=%h expected 1 7 %h", ops[i], we, rdo, res, exp[31:0]);
      end
      issue(0, ops[i], 32'hF0F0_A5A5, 32'h0FF0_FFFF, 4'd0, lat, we, il, rdo, res);
      checks++;
      if ({lat == 8, we, il} !== 3'b100) begin
        errors++;
        $display("FAIL x0_suppress op=%b: lat=%0d wr_en=%b illegal=%b expected lat 8 wr_en 0 illegal 0", ops[i], lat, we, il);
      end
    end
  endtask

  task automatic test_illegal;
    int lat; logic we, il; logic [3:0] rdo; logic [31:0] res;
    issue(0, 4'b0001, 32'h1234_5678, 32'h1111_1111, 4'd3, lat, we, il, rdo, res);
    checks++;
    if ({lat == 8, we, il, res} !== {1'b1, 1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL illegal_0001: lat=%0d wr_en=%b illegal=%b rd_in=%h expected lat 8, 0, 1, 00000000", lat, we, il, res);
    end
    @(negedge clk);
    checks++;
    if (illegal_v[0] !== 1'b0) begin errors++; $display("FAIL illegal_pulse_width: illegal=%b expected 0", illegal_v[0]); end
    for (int i = 0; i < 4; i++) begin
      logic [3:0] o;
      o = illegal_ops[$urandom_range(8, 0)];
      issue(0, o, $urandom, $urandom, 4'($urandom_range(15, 1)), lat, we, il, rdo, res);
      checks++;
      if ({lat == 8, we, il, res} !== {1'b1, 1'b0, 1'b1, 32'h0}) begin
        errors++;
        $display("FAIL illegal_rand op=%b: lat=%0d wr_en=%b illegal=%b rd_in=%h", o, lat, we, il, res);
      end
    end
  endtask

  task automatic test_ignored_start;
    int lat;
    op = 4'b0000; a = 32'd100; b = 32'd23; rd_addr = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    op = 4'b1000; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; rd_addr = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 4;
    while (busy_v[0] === 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    checks++;
    if ({lat == 8, wr_en_v[0], rd_v[0], rd_in_v[0]} !== {1'b1, 1'b1, 4'd9, 32'd123}) begin
      errors++;
      $display("FAIL ignored_start: lat=%0d wr_en=%b rd=%0d rd_in=%h expected 8 1 9 0000007b",
               lat, wr_en_v[0], rd_v[0], rd_in_v[0]);
    end
    @(negedge clk);
    checks++;
    if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL ignored_start_queued: busy=%b expected 0", busy_v[0]); end
  endtask

  task automatic test_back_to_back;
    int lat; logic we, il; logic [3:0] rdo; logic [31:0] res; logic [32:0] exp;
    issue(0, 4'b0000, 32'h0000_1000, 32'h0000_0234, 4'd4, lat, we, il, rdo, res);
    checks++;
    if ({we, res} !== {1'b1, 32'h0000_1234}) begin
      errors++;
      $display("FAIL b2b_first: wr_en=%b rd_in=%h expected 1 00001234", we, res);
    end
    exp = ref_alu(4'b1000, 32'h0000_0010, 32'h0000_0020);
    issue(0, 4'b1000, 32'h0000_0010, 32'h0000_0020, 4'd6, lat, we, il, rdo, res);
    checks++;
    if ({lat == 8, we, rdo, res} !== {1'b1, 1'b1, 4'd6, exp[31:0]}) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d wr_en=%b rd=%0d rd_in=%h expected 8 1 6 %h", lat, we, rdo, res, exp[31:0]);
    end
  endtask

  task automatic test_random;
    int lat; logic we, il; logic [3:0] rdo; logic [31:0] res; logic [32:0] exp;
    logic [3:0] o, r; logic [31:0] x, y;
    for (int n = 0; n < 60; n++) begin
      o = ($urandom_range(9, 0) == 0) ? illegal_ops[$urandom_range(8, 0)] : legal_ops[$urandom_range(6, 0)];
      r = 4'($urandom);
      x = $urandom; y = $urandom;
      if ($urandom_range(3, 0) == 0) x = {x[31], 31'($urandom_range(3, 0))};
      if ($urandom_range(3, 0) == 0) y = x;
      exp = ref_alu(o, x, y);
      issue(0, o, x, y, r, lat, we, il, rdo, res);
      checks++;
      if (lat != 8 || we !== (exp[32] && r != 0) || il !== !exp[32] ||
          (we && (rdo !== r || res !== exp[31:0]))) begin
        errors++;
        $display("FAIL random[%0d] op=%b a=%h b=%h rd=%0d: lat=%0d wr_en=%b illegal=%b rd=%0d rd_in=%h expected rd_in %h",
                 n, o, x, y, r, lat, we, il, rdo, res, exp[31:0]);
      end
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    bit saw_we = 0;
    op = 4'b0000; a = 32'h55; b = 32'h22; rd_addr = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: busy=%b expected 0", busy_v[0]); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (wr_en_v[0] !== 1'b0) saw_we = 1;
    end
    checks++;
    if (saw_we) begin errors++; $display("FAIL reset_mid_write: wr_en observed 1, expected never"); end
    checks++;
    if ({busy_v[0], wr_en_v[0], illegal_v[0], rd_v[0], rd_in_v[0]} !== 39'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: busy=%b wr_en=%b illegal=%b rd=%h rd_in=%h, all must be 0",
               busy_v[0], wr_en_v[0], illegal_v[0], rd_v[0], rd_in_v[0]);
    end
  endtask

  task automatic test_sweep;
    int lat; logic we, il; logic [3:0] rdo; logic [31:0] res; logic [31:0] x, y;
    repeat (40) @(negedge clk);
    for (int idx = 1; idx < NDUT; idx++) begin
      x = $urandom; y = $urandom;
      issue(idx, 4'b0000, x, y, 4'd11, lat, we, il, rdo, res);
      checks++;
      if (lat != 32 / BPC_TAB[idx] || we !== 1'b1 || res !== x + y) begin
        errors++;
        $display("FAIL sweep bpc=%0d: lat=%0d wr_en=%b rd_in=%h expected lat %0d wr_en 1 rd_in %h",
                 BPC_TAB[idx], lat, we, res, 32 / BPC_TAB[idx], x + y);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sub_cmp();
    test_logic_x0();
    test_illegal();
    test_ignored_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tinyqv_serial_alu.md
Name: tinyqv_serial_alu

Overview:
- Execute stage directly downstream of tinyqv_registers.
- Consumes the rs1_out/rs2_out operand pair and processes it BITS_PER_CYCLE bits per clock, LSB first.
- Produces the rd_in/wr_en/rd write-back triple that feeds straight back into the register file.
- Keeps the area-minimal philosophy: one narrow adder slice reused over several cycles instead of a 32-bit adder.

Parameters:
- BITS_PER_CYCLE, 4: slice width per clock. Legal values are 1, 2, 4, 8. Latency is 32/BITS_PER_CYCLE cycles.
- NUM_SLICES, 32/BITS_PER_CYCLE: derived, not overridable.

Ports:
- clk  input  1  core clock; all state on rising edge.
- rstn  input  1  reset; asynchronous, active-low.
- start  input  1  request; sampled only when busy=0.
- op  input  4  {funct7[5], funct3}: 0000 ADD, 1000 SUB, 0010 SLT, 0011 SLTU, 0100 XOR, 0110 OR, 0111 AND; all others illegal.
- rd_addr  input  4  destination register index (x0..x15, RV32E).
- a  input  32  operand 1 (register file rs1_out).
- b  input  32  operand 2 (register file rs2_out or immediate).
- busy  output  1  operation in flight.
- wr_en  output  1  one-cycle write strobe to register file.
- rd  output  4  latched destination index.
- rd_in  output  32  result to register file.
- illegal  output  1  one-cycle pulse: unsupported op completed.

Behaviour:
- Reset: busy=0, wr_en=0, illegal=0, rd=0, rd_in=0, slice counter=0, carry=0. Reset mid-operation aborts with no write.
- Accept: start=1 with busy=0 at edge E0.
  - Latches a, b, op and rd_addr.
  - busy rises after E0.
  - carry_in is set to 1 for SUB/SLT/SLTU, else 0.
  - start while busy=1 is ignored; no queueing.
- Slice k (k=0..NUM_SLICES-1) is computed at edge E(k+1):
  - Operand registers shift right by BITS_PER_CYCLE.
  - Result slice shifts into the top of the result register.
  - Carry is registered between slices.
  - ADD: a+b. SUB/SLT/SLTU: a+~b+carry. XOR/OR/AND: bitwise, carry unused.
- Completion at edge E(NUM_SLICES), i.e. E8 for the default:
  - busy falls.
  - wr_en=1 for exactly one cycle, unless rd=0 (x0 writes suppressed) or op is illegal.
  - rd and rd_in are valid while wr_en=1 and hold until the next completion.
- SLTU: rd_in = {31'b0, ~carry_out}.
- SLT: lt = (a[31]^b[31]) ? a[31] : diff[31]; rd_in = {31'b0, lt}.
  - Sign bits are captured at accept, since the operand register shifts.
- Illegal op:
  - Runs the full latency.
  - rd_in = 0, wr_en=0, illegal=1 for one cycle at completion.
- Back-to-back: start may be asserted in the wr_en cycle. Busy is low there, so the new op is accepted. Peak throughput is one op per NUM_SLICES+1 cycles.
- Wrap-around: ADD/SUB are modulo 2^32. Final carry is discarded except for SLTU/SLT.

Decomposition:
- Shared package tinyqv_alu_pkg holds:
  - op encoding constants (ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND);
  - REG_ADDR_W=4 and XLEN=32, which tinyqv_registers also uses.
- One natural sub-module, tinyqv_alu_slice: a combinational BITS_PER_CYCLE-wide add/logic slice with carry in/out.
- The top holds the counter, shift registers, SLT/SLTU fix-up and handshake.

Test Plan:
- Reset mid-op: start ADD at E0, deassert rstn at E3 → busy=0, wr_en never asserts; after release, outputs are all zero.
- ADD wrap: a=0xFFFFFFFF, b=0x00000001, rd=5 → busy for 8 cycles, then wr_en=1 one cycle, rd=5, rd_in=0x00000000.
- SUB/SLT/SLTU: a=0x00000003, b=0xFFFFFFFE → SUB rd_in=0x00000005; SLT rd_in=0; SLTU rd_in=1. Swapped operands → SLT=1, SLTU=0.
- Logic and x0: a=0xF0F0A5A5, b=0x0FF0FFFF → XOR 0xFF005A5A, OR 0xFFF0FFFF, AND 0x00F0A5A5. Repeat with rd=0 → wr_en stays 0.
- Illegal/ignored start: op=0001 → illegal pulses once after 8 cycles, wr_en=0. A start pulse during busy with different operands leaves the in-flight result unchanged.
- Back-to-back and parameter sweep: start asserted during the wr_en cycle → second result after exactly 9 further cycles. Rerun ADD at BITS_PER_CYCLE=1, 2, 8 → latency 32, 16, 4.
